// File: rtl/tap_pkg.sv
// Shared JTAG TAP definitions: TDO source-select encoding and the idle TDO level.
package tap_pkg;

    typedef enum logic [1:0] {
        TDO_SEL_IDLE   = 2'b00,
        TDO_SEL_DR     = 2'b01,
        TDO_SEL_SCAN   = 2'b10,
        TDO_SEL_BYPASS = 2'b11
    } tdo_sel_e;

    localparam logic TDO_IDLE_VALUE = 1'b0;

endpackage

// File: rtl/pb_tdo_dr_mux.sv
// TDO output-select stage: muxes DR / scan / bypass serial data onto TDO, with a
// zero-latency combinational path and a shift-qualified registered TDO/OE pair.
module pb_tdo_dr_mux
    import tap_pkg::*;
#(
    parameter logic RESET_TDO  = 1'b0,
    parameter logic IDLE_VALUE = TDO_IDLE_VALUE
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] sel_i,
    input  logic       dr_i,
    input  logic       scan_i,
    input  logic       bypass_i,
    input  logic       shift_i,
    output logic       tdo_o,
    output logic       tdo_q_o,
    output logic       tdo_oe_o
);

    logic w_tdo;
    logic r_tdo_q;
    logic r_tdo_oe;

    // An unknown select falls to the default arm so TDO parks at the idle level.
    always_comb begin
        w_tdo = IDLE_VALUE;
        case (sel_i)
            TDO_SEL_DR:     w_tdo = dr_i;
            TDO_SEL_SCAN:   w_tdo = scan_i;
            TDO_SEL_BYPASS: w_tdo = bypass_i;
            default:        w_tdo = IDLE_VALUE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tdo_q  <= RESET_TDO;
            r_tdo_oe <= 1'b0;
        end else begin
            if (shift_i) begin
                r_tdo_q <= w_tdo;
            end
            r_tdo_oe <= shift_i & (sel_i != TDO_SEL_IDLE);
        end
    end

    assign tdo_o    = w_tdo;
    assign tdo_q_o  = r_tdo_q;
    assign tdo_oe_o = r_tdo_oe;

endmodule

// File: tb/tb_pb_tdo_dr_mux.sv
// Scoreboard bench for pb_tdo_dr_mux: expectations are queued as stimulus is
// driven and drained against the DUT outputs once they are due.
module tb_pb_tdo_dr_mux;

    localparam int PORT_TDO = 0;
    localparam int PORT_Q   = 1;
    localparam int PORT_OE  = 2;

    typedef struct {
        string tag;
        int    port;
        logic  expected;
    } expect_t;

    logic       clk;
    logic       rstN;
    logic [1:0] sel;
    logic       dr;
    logic       scan;
    logic       bypass;
    logic       shift;
    logic       tdo;
    logic       tdoQ;
    logic       tdoOe;

    expect_t scoreboard[$];
    int      checks;
    int      failures;

    pb_tdo_dr_mux dut (
        .clk_i    (clk),
        .rst_ni   (rstN),
        .sel_i    (sel),
        .dr_i     (dr),
        .scan_i   (scan),
        .bypass_i (bypass),
        .shift_i  (shift),
        .tdo_o    (tdo),
        .tdo_q_o  (tdoQ),
        .tdo_oe_o (tdoOe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic modelTdo(input logic [1:0] s, input logic d,
                                      input logic sc, input logic b);
        case (s)
            2'b01:   return d;
            2'b10:   return sc;
            2'b11:   return b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic observe(input int port);
        case (port)
            PORT_TDO: return tdo;
            PORT_Q:   return tdoQ;
            default:  return tdoOe;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic pushExpect(input string tag, input int port, input logic expected);
        expect_t e;
        e.tag      = tag;
        e.port     = port;
        e.expected = expected;
        scoreboard.push_back(e);
    endtask

    task automatic drainScoreboard();
        expect_t e;
        while (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            checkOutput(e.tag, observe(e.port), e.expected);
        end
    endtask

    // Drives all data-path inputs and queues the combinational TDO they imply.
    task automatic applyStimulus(input string tag, input logic [1:0] s, input logic d,
                                 input logic sc, input logic b, input logic sh);
        sel    = s;
        dr     = d;
        scan   = sc;
        bypass = b;
        shift  = sh;
        pushExpect(tag, PORT_TDO, modelTdo(s, d, sc, b));
    endtask

    task automatic combStep(input string tag, input logic [1:0] s, input logic d,
                            input logic sc, input logic b, input logic sh);
        @(negedge clk);
        applyStimulus(tag, s, d, sc, b, sh);
        #1;
        drainScoreboard();
    endtask

    task automatic edgeThenDrain();
        @(posedge clk);
        #1;
        drainScoreboard();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstN     = 1'b0;
        sel      = 2'b00;
        dr       = 1'b0;
        scan     = 1'b0;
        bypass   = 1'b0;
        shift    = 1'b0;

        #1;
        pushExpect("reset_q", PORT_Q, 1'b0);
        pushExpect("reset_oe", PORT_OE, 1'b0);
        drainScoreboard();

        combStep("dr_hi",     2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        combStep("dr_lo",     2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        combStep("scan_hi",   2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        combStep("scan_lo",   2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        combStep("bypass_hi", 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
        combStep("bypass_lo", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        combStep("idle_ones", 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);

        @(negedge clk);
        sel = 2'bxx;
        dr = 1'b1; scan = 1'b1; bypass = 1'b1;
        pushExpect("sel_x_idle", PORT_TDO, 1'b0);
        #1;
        drainScoreboard();

        for (int i = 0; i < 8; i++) begin
            combStep("rand_comb", 2'($urandom_range(3)), 1'($urandom_range(1)),
                     1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
        end

        pushExpect("reset_hold_q", PORT_Q, 1'b0);
        pushExpect("reset_hold_oe", PORT_OE, 1'b0);
        edgeThenDrain();

        @(negedge clk);
        rstN = 1'b1;
        applyStimulus("shift_dr_tdo", 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        drainScoreboard();
        pushExpect("shift_dr_q", PORT_Q, 1'b1);
        pushExpect("shift_dr_oe", PORT_OE, 1'b1);
        edgeThenDrain();

        @(negedge clk);
        applyStimulus("selchg_tdo", 2'b10, 1'b1, 1'b0, 1'b0, 1'b1);
        pushExpect("selchg_q_before_edge", PORT_Q, 1'b1);
        #1;
        drainScoreboard();
        pushExpect("selchg_q", PORT_Q, 1'b0);
        pushExpect("selchg_oe", PORT_OE, 1'b1);
        edgeThenDrain();

        combStep("reload_tdo", 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
        pushExpect("reload_q", PORT_Q, 1'b1);
        edgeThenDrain();

        combStep("shift_off_tdo", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        pushExpect("shift_off_q_hold", PORT_Q, 1'b1);
        pushExpect("shift_off_oe", PORT_OE, 1'b0);
        edgeThenDrain();

        combStep("stop_and_sel_tdo", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        pushExpect("stop_and_sel_q_hold", PORT_Q, 1'b1);
        pushExpect("stop_and_sel_oe", PORT_OE, 1'b0);
        edgeThenDrain();

        combStep("shift_idle_tdo", 2'b00, 1'b1, 1'b1, 1'b1, 1'b1);
        pushExpect("shift_idle_q", PORT_Q, 1'b0);
        pushExpect("shift_idle_oe", PORT_OE, 1'b0);
        edgeThenDrain();

        combStep("bypass_shift_tdo", 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
        pushExpect("bypass_shift_q", PORT_Q, 1'b1);
        pushExpect("bypass_shift_oe", PORT_OE, 1'b1);
        edgeThenDrain();

        #1;
        rstN = 1'b0;
        pushExpect("midshift_rst_q", PORT_Q, 1'b0);
        pushExpect("midshift_rst_oe", PORT_OE, 1'b0);
        pushExpect("midshift_rst_tdo", PORT_TDO, 1'b1);
        #1;
        drainScoreboard();

        combStep("rst_tdo_follow", 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        pushExpect("rst_edge_q", PORT_Q, 1'b0);
        pushExpect("rst_edge_oe", PORT_OE, 1'b0);
        edgeThenDrain();

        @(negedge clk);
        rstN = 1'b1;
        applyStimulus("post_rst_tdo", 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        drainScoreboard();
        pushExpect("post_rst_q", PORT_Q, 1'b1);
        pushExpect("post_rst_oe", PORT_OE, 1'b1);
        edgeThenDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
